// File: rtl/temp_ascii_fmt.sv
// Formats one signed LTC2986 temperature sample as "+dddd.fff\r\n" and streams it byte by byte to the UART.
// Define TEMP_FMT_FAULT_EN to append " Fxx" (hex fault byte) before CR/LF.
module temp_ascii_fmt #(
  parameter int FRAC_BITS    = 10,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] temp_raw,
  input  logic [7:0]  temp_fault,
  input  logic        temp_valid,
  input  logic        uart_busy,
  output logic        uart_start,
  output logic [7:0]  uart_data,
  output logic        fmt_busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam int INT_BITS = 23 - FRAC_BITS;
  localparam int FRAC_W   = 10;
  localparam int PROD_W   = FRAC_BITS + 10;
  localparam int CONV_CYC = (INT_BITS > FRAC_W) ? INT_BITS : FRAC_W;
  localparam int TO_W     = $clog2(BUSY_TIMEOUT + 1);
`ifdef TEMP_FMT_FAULT_EN
  localparam logic [3:0] LAST_IDX = 4'd14;
`else
  localparam logic [3:0] LAST_IDX = 4'd10;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t              state_q, state_d;
  logic [23:0]         cur_raw_q, cur_raw_d, pend_raw_q, pend_raw_d;
  logic [7:0]          cur_fault_q, cur_fault_d, pend_fault_q, pend_fault_d;
  logic                pend_vld_q, pend_vld_d;
  logic [7:0]          drop_q, drop_d;
  logic                neg_q, neg_d;
  logic [INT_BITS-1:0] int_bin_q, int_bin_d;
  logic [FRAC_W-1:0]   frac_bin_q, frac_bin_d;
  logic [15:0]         int_bcd_q, int_bcd_d;
  logic [11:0]         frac_bcd_q, frac_bcd_d;
  logic [3:0]          cnt_q, cnt_d, idx_q, idx_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                done_q, done_d;
  logic [22:0]         abs_mag, mag;
  logic [FRAC_W-1:0]   frac_val;
  logic [7:0]          frame_byte;

  function automatic logic [15:0] bcd_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (r[4*i +: 4] > 4'd4) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

`ifdef TEMP_FMT_FAULT_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction
`else
  logic unused_fault;
  assign unused_fault = ^cur_fault_q;
`endif

  // -2^23 has no positive 24-bit counterpart, so it clamps to the largest magnitude.
  always_comb begin
    abs_mag  = cur_raw_q[23] ? (~cur_raw_q[22:0] + 23'd1) : cur_raw_q[22:0];
    mag      = (cur_raw_q == 24'h800000) ? 23'h7FFFFF : abs_mag;
    frac_val = FRAC_W'((PROD_W'(mag[FRAC_BITS-1:0]) * PROD_W'(1000)) >> FRAC_BITS);
  end

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:    frame_byte = neg_q ? 8'h2D : 8'h2B;
      4'd1:    frame_byte = {4'h3, int_bcd_q[15:12]};
      4'd2:    frame_byte = {4'h3, int_bcd_q[11:8]};
      4'd3:    frame_byte = {4'h3, int_bcd_q[7:4]};
      4'd4:    frame_byte = {4'h3, int_bcd_q[3:0]};
      4'd5:    frame_byte = 8'h2E;
      4'd6:    frame_byte = {4'h3, frac_bcd_q[11:8]};
      4'd7:    frame_byte = {4'h3, frac_bcd_q[7:4]};
      4'd8:    frame_byte = {4'h3, frac_bcd_q[3:0]};
`ifdef TEMP_FMT_FAULT_EN
      4'd9:    frame_byte = 8'h20;
      4'd10:   frame_byte = 8'h46;
      4'd11:   frame_byte = hex_ascii(cur_fault_q[7:4]);
      4'd12:   frame_byte = hex_ascii(cur_fault_q[3:0]);
      4'd13:   frame_byte = 8'h0D;
      4'd14:   frame_byte = 8'h0A;
`else
      4'd9:    frame_byte = 8'h0D;
      4'd10:   frame_byte = 8'h0A;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cur_raw_d    = cur_raw_q;
    cur_fault_d  = cur_fault_q;
    pend_vld_d   = pend_vld_q;
    pend_raw_d   = pend_raw_q;
    pend_fault_d = pend_fault_q;
    drop_d       = drop_q;
    neg_d        = neg_q;
    int_bin_d    = int_bin_q;
    frac_bin_d   = frac_bin_q;
    int_bcd_d    = int_bcd_q;
    frac_bcd_d   = frac_bcd_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    to_d         = to_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          cur_raw_d   = pend_raw_q;
          cur_fault_d = pend_fault_q;
          pend_vld_d  = 1'b0;
          state_d     = S_LOAD;
        end else if (temp_valid) begin
          cur_raw_d   = temp_raw;
          cur_fault_d = temp_fault;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        neg_d      = cur_raw_q[23];
        int_bin_d  = mag[22:FRAC_BITS];
        frac_bin_d = frac_val;
        int_bcd_d  = '0;
        frac_bcd_d = '0;
        cnt_d      = '0;
        state_d    = S_CONV;
      end
      S_CONV: begin
        int_bcd_d = (bcd_adj(int_bcd_q) << 1) | 16'(int_bin_q[INT_BITS-1]);
        int_bin_d = int_bin_q << 1;
        // The fraction needs fewer shifts; it simply stops once its bits are consumed.
        if (cnt_q < 4'(FRAC_W)) begin
          frac_bcd_d = 12'((bcd_adj({4'd0, frac_bcd_q}) << 1) | 16'(frac_bin_q[FRAC_W-1]));
          frac_bin_d = frac_bin_q << 1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(CONV_CYC - 1)) begin
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        to_d    = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (uart_busy || to_q == TO_W'(BUSY_TIMEOUT - 1)) state_d = S_WAIT_LO;
        else to_d = to_q + 1'b1;
      end
      S_WAIT_LO: begin
        if (!uart_busy) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // In IDLE the slot is being drained this cycle, so refilling it is not a drop.
    if (temp_valid && (state_q != S_IDLE || pend_vld_q)) begin
      pend_raw_d   = temp_raw;
      pend_fault_d = temp_fault;
      pend_vld_d   = 1'b1;
      if (pend_vld_q && state_q != S_IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_raw_q    <= '0;
      cur_fault_q  <= '0;
      pend_vld_q   <= 1'b0;
      pend_raw_q   <= '0;
      pend_fault_q <= '0;
      drop_q       <= '0;
      neg_q        <= 1'b0;
      int_bin_q    <= '0;
      frac_bin_q   <= '0;
      int_bcd_q    <= '0;
      frac_bcd_q   <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      to_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_raw_q    <= cur_raw_d;
      cur_fault_q  <= cur_fault_d;
      pend_vld_q   <= pend_vld_d;
      pend_raw_q   <= pend_raw_d;
      pend_fault_q <= pend_fault_d;
      drop_q       <= drop_d;
      neg_q        <= neg_d;
      int_bin_q    <= int_bin_d;
      frac_bin_q   <= frac_bin_d;
      int_bcd_q    <= int_bcd_d;
      frac_bcd_q   <= frac_bcd_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      to_q         <= to_d;
      done_q       <= done_d;
    end
  end

  assign uart_start = (state_q == S_SEND);
  assign uart_data  = uart_start ? frame_byte : 8'h00;
  assign fmt_busy   = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign drop_cnt   = drop_q;

endmodule
